// File: rtl/vmem_arbiter.sv
// Two-requester vector memory arbiter with in-order response routing; macro VMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: request forwarded and response routed combinationally (zero cycles); the response FIFO holds up to MAX_OUTST IDs.
// Backpressure: a requester waits for mem_gnt_i; mem_req_o is held low while MAX_OUTST transactions are outstanding.

module vmem_arb_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module vmem_arbiter #(
    parameter int VMEM_W    = 128,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 req_i,
    output logic [1:0]                 gnt_o,
    input  logic [1:0][31:0]           addr_i,
    input  logic [1:0]                 we_i,
    input  logic [1:0][VMEM_W/8-1:0]   be_i,
    input  logic [1:0][VMEM_W-1:0]     wdata_i,
    output logic [1:0]                 rvalid_o,
    output logic [VMEM_W-1:0]          rdata_o,
    output logic [1:0]                 err_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [VMEM_W/8-1:0]        mem_be_o,
    output logic [VMEM_W-1:0]          mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic [VMEM_W-1:0]          mem_rdata_i,
    input  logic                       mem_err_i,
    output logic                       spurious_rsp_o
);
    localparam int CW = $clog2(MAX_OUTST) + 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state_q;
    logic          owner_q;
    logic          spurious_q;
    logic          winner;
    logic          sel;
    logic          mem_req;
    logic          push;
    logic          pop;
    logic          head_id;
    logic [CW-1:0] count;

`ifdef VMEM_ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rr_ptr_q <= 1'b0;
        else if (push) rr_ptr_q <= ~sel;
    end

    // A lone requester always wins; only a tie consults the pointer.
    assign winner = (req_i == 2'b11) ? rr_ptr_q : ~req_i[0];
`else
    assign winner = ~req_i[0];
`endif

    assign sel     = (state_q == LOCKED) ? owner_q : winner;
    assign mem_req = (state_q == LOCKED) ? req_i[owner_q]
                                         : ((|req_i) && (count < CW'(MAX_OUTST)));
    assign push    = mem_req & mem_gnt_i;
    assign pop     = mem_rvalid_i & (count != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            if (mem_rvalid_i && (count == '0)) spurious_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_gnt_i) begin
                        state_q <= LOCKED;
                        owner_q <= winner;
                    end
                end
                LOCKED: begin
                    // Owner dropping its request abandons the transfer without a push.
                    if (!req_i[owner_q] || mem_gnt_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    vmem_arb_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTST)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push),
        .push_dat (sel),
        .pop      (pop),
        .head_dat (head_id),
        .count    (count)
    );

    // Outputs are forced quiet while reset is held, even with requests pending.
    assign mem_req_o      = mem_req & rst_ni;
    assign gnt_o          = {push & sel & rst_ni, push & ~sel & rst_ni};
    assign mem_addr_o     = addr_i[sel];
    assign mem_we_o       = we_i[sel];
    assign mem_be_o       = be_i[sel];
    assign mem_wdata_o    = wdata_i[sel];
    assign rvalid_o       = {pop & head_id, pop & ~head_id};
    assign err_o          = {pop & mem_err_i & head_id, pop & mem_err_i & ~head_id};
    assign rdata_o        = mem_rdata_i;
    assign spurious_rsp_o = spurious_q;
endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: transaction-level reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_vmem_arbiter;
    localparam int W  = 128;
    localparam int BW = W / 8;
    localparam int MO = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [1:0]           req_i;
    logic [1:0]           gnt_o;
    logic [1:0][31:0]     addr_i;
    logic [1:0]           we_i;
    logic [1:0][BW-1:0]   be_i;
    logic [1:0][W-1:0]    wdata_i;
    logic [1:0]           rvalid_o;
    logic [W-1:0]         rdata_o;
    logic [1:0]           err_o;
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic [31:0]          mem_addr_o;
    logic                 mem_we_o;
    logic [BW-1:0]        mem_be_o;
    logic [W-1:0]         mem_wdata_o;
    logic                 mem_rvalid_i;
    logic [W-1:0]         mem_rdata_i;
    logic                 mem_err_i;
    logic                 spurious_rsp_o;

    int checks   = 0;
    int failures = 0;

    vmem_arbiter #(.VMEM_W(W), .MAX_OUTST(MO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .spurious_rsp_o (spurious_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of requester IDs awaiting responses, plus which
    // requester (if any) has been offered downstream but not yet accepted.
    bit m_q[$];
    bit m_pend;
    bit m_owner;
    bit m_rr;
    bit m_spur;

    always @(negedge clk_i) begin
        bit         e_req, e_sel, e_pop, head, lone;
        logic [1:0] e_gnt, e_rv, e_err;
        if (!rst_ni) begin
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_spurious", spurious_rsp_o, 0);
            m_q.delete();
            m_pend = 0;
            m_owner = 0;
            m_rr = 0;
            m_spur = 0;
        end else begin
            lone = (req_i != 2'b11);
            if (m_pend) begin
                e_req = req_i[m_owner];
                e_sel = m_owner;
            end else begin
                e_req = (req_i != 2'b00) && (m_q.size() < MO);
`ifdef VMEM_ARB_ROUND_ROBIN_EN
                e_sel = lone ? req_i[1] : m_rr;
`else
                e_sel = lone ? req_i[1] : 1'b0;
`endif
            end
            e_gnt = (e_req && mem_gnt_i) ? (2'b01 << e_sel) : 2'b00;
            e_pop = mem_rvalid_i && (m_q.size() > 0);
            head  = e_pop ? m_q[0] : 1'b0;
            e_rv  = e_pop ? (2'b01 << head) : 2'b00;
            e_err = (e_pop && mem_err_i) ? (2'b01 << head) : 2'b00;

            chk("mem_req", mem_req_o, e_req);
            chk("gnt", gnt_o, e_gnt);
            chk("rvalid", rvalid_o, e_rv);
            chk("err", err_o, e_err);
            chk("spurious", spurious_rsp_o, m_spur);
            if (e_req) begin
                chk("mem_addr", mem_addr_o, addr_i[e_sel]);
                chk("mem_we", mem_we_o, we_i[e_sel]);
                chk("mem_be", mem_be_o, be_i[e_sel]);
                chk("mem_wdata", mem_wdata_o, wdata_i[e_sel]);
            end
            if (e_pop) chk("rdata", rdata_o, mem_rdata_i);

            if (mem_rvalid_i && m_q.size() == 0) m_spur = 1;
            if (e_pop) void'(m_q.pop_front());
            if (e_gnt != 2'b00) begin
                m_q.push_back(e_sel);
                m_rr = ~e_sel;
            end
            if (m_pend) begin
                if (!req_i[m_owner] || mem_gnt_i) m_pend = 0;
            end else if (e_req && !mem_gnt_i) begin
                m_pend = 1;
                m_owner = e_sel;
            end
        end
    end

    task automatic idle_inputs();
        req_i = 2'b00;
        mem_gnt_i = 0;
        mem_rvalid_i = 0;
        mem_err_i = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 0;
        idle_inputs();
        req_i = 2'b11;
        mem_gnt_i = 1;
        @(negedge clk_i);
        chk("rst_hold_mem_req", mem_req_o, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        idle_inputs();
    endtask

    // One bus cycle: drive after the edge, return at the falling edge for sampling.
    task automatic cyc(input logic [1:0] r, input logic g, input logic rv, input logic e);
        @(posedge clk_i); #1;
        req_i = r;
        mem_gnt_i = g;
        mem_rvalid_i = rv;
        mem_err_i = e;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp30 [4];
        logic [W-1:0] aa;
`ifdef VMEM_ARB_ROUND_ROBIN_EN
        exp30 = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp30 = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        aa = {BW{8'hAA}};
        rst_ni = 0;
        idle_inputs();
        addr_i = '{32'h0000_2000, 32'h0000_1000};
        we_i = 2'b01;
        be_i = '{{BW{1'b1}}, {BW{1'b0}}};
        wdata_i = '{{W{1'b0}}, {W{1'b1}}};
        mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        do_reset();

        // Single read: grant same cycle, response two cycles later.
        cyc(2'b01, 1, 0, 0);
        chk("d29_gnt", gnt_o, 2'b01);
        chk("d29_addr", mem_addr_o, 32'h0000_1000);
        cyc(2'b00, 0, 0, 0);
        mem_rdata_i = aa;
        cyc(2'b00, 0, 1, 0);
        chk("d29_rvalid", rvalid_o, 2'b01);
        chk("d29_rdata", rdata_o, aa);

        // Both requesting with immediate grants, then the outstanding limit.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 1, 0, 0);
            chk("d30_gnt_seq", gnt_o, exp30[i]);
        end
        cyc(2'b11, 1, 1, 0);
        chk("d32_full_mem_req", mem_req_o, 1'b0);
        chk("d32_full_gnt", gnt_o, 2'b00);
        chk("d32_pop_rvalid", rvalid_o, 2'b01);
        cyc(2'b11, 0, 0, 0);
        chk("d32_resume_mem_req", mem_req_o, 1'b1);

        // Locked owner keeps the bus while the other requester arrives.
        do_reset();
        cyc(2'b10, 0, 0, 0);
        chk("d31_addr_c0", mem_addr_o, 32'h0000_2000);
        cyc(2'b11, 0, 0, 0);
        chk("d31_addr_c1", mem_addr_o, 32'h0000_2000);
        cyc(2'b11, 0, 0, 0);
        chk("d31_gnt_c2", gnt_o, 2'b00);
        cyc(2'b11, 1, 0, 0);
        chk("d31_gnt_c3", gnt_o, 2'b10);

        // Responses return in grant order with error routed to its owner.
        do_reset();
        cyc(2'b01, 1, 0, 0);
        cyc(2'b10, 1, 0, 0);
        cyc(2'b01, 1, 0, 0);
        cyc(2'b00, 0, 1, 0);
        chk("d33_rv0", rvalid_o, 2'b01);
        chk("d33_err0", err_o, 2'b00);
        cyc(2'b00, 0, 1, 1);
        chk("d33_rv1", rvalid_o, 2'b10);
        chk("d33_err1", err_o, 2'b10);
        cyc(2'b00, 0, 1, 0);
        chk("d33_rv2", rvalid_o, 2'b01);
        chk("d33_err2", err_o, 2'b00);

        // Response with nothing outstanding is dropped and flagged until reset.
        cyc(2'b00, 0, 1, 0);
        chk("d34_rvalid", rvalid_o, 2'b00);
        cyc(2'b00, 0, 0, 0);
        chk("d34_spur_set", spurious_rsp_o, 1'b1);
        do_reset();
        @(negedge clk_i);
        chk("d34_spur_clear", spurious_rsp_o, 1'b0);

        // Randomized traffic, including protocol violations and mid-flight resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            @(posedge clk_i); #1;
            req_i = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                addr_i[r]  = $urandom();
                we_i[r]    = 1'($urandom_range(0, 1));
                be_i[r]    = {$urandom(), $urandom(), $urandom(), $urandom()};
                wdata_i[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            mem_gnt_i    = ($urandom_range(0, 99) < 55);
            mem_rvalid_i = ($urandom_range(0, 99) < 40);
            mem_err_i    = ($urandom_range(0, 99) < 20);
            mem_rdata_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
